// File: rtl/pc_branch_unit.sv
// Program counter and branch sequencer: IDLE/RUN/DONE run control, sequential
// fetch addressing, and LUT-resolved absolute targets for taken branches.
module pc_branch_unit #(
  parameter int PCW = 10,
  parameter int LW  = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [PCW-1:0] StartAddr,
  input  logic           Halt,
  input  logic           BranchEn,
  input  logic [LW-1:0]  BranchIdx,
  input  logic           CondIn,
  input  logic           LutWrEn,
  input  logic [LW-1:0]  LutWrIdx,
  input  logic [PCW-1:0] LutWrData,
  output logic [PCW-1:0] ProgCtr,
  output logic           Running,
  output logic           Done,
  output logic           BranchTaken
);

  localparam int LUT_N = 2 ** LW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [PCW-1:0] lut_reg [LUT_N];
  logic [PCW-1:0] lut_rd;
  logic           lut_wr_ok;
  logic [LUT_N-1:0] lut_we;

  // The table is frozen while a program runs so targets cannot shift mid-run.
  assign lut_wr_ok = LutWrEn && (state_reg != S_RUN);

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut_we
      assign lut_we[gi] = lut_wr_ok && (LutWrIdx == LW'(gi));
    end
  endgenerate

  // Every entry must clear on reset, so the table lives in flops, not RAM.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < LUT_N; i++) begin
      if (Reset) begin
        lut_reg[i] <= '0;
      end else if (lut_we[i]) begin
        lut_reg[i] <= LutWrData;
      end
    end
  end

  assign lut_rd = lut_reg[BranchIdx];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= S_IDLE;
      ProgCtr     <= '0;
      BranchTaken <= 1'b0;
    end else begin
      BranchTaken <= 1'b0;
      unique case (state_reg)
        S_IDLE, S_DONE: begin
          if (Start) begin
            ProgCtr   <= StartAddr;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (Halt) begin
            state_reg <= S_DONE;
          end else if (BranchEn && CondIn) begin
            ProgCtr     <= lut_rd;
            BranchTaken <= 1'b1;
          end else begin
            ProgCtr <= ProgCtr + PCW'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign Running = (state_reg == S_RUN);
  assign Done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: run control, branching, wrap, halt and
// LUT write gating, with hand-computed expectations.
module tb_pc_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [9:0] StartAddr = '0;
  logic       Halt = 1'b0;
  logic       BranchEn = 1'b0;
  logic [4:0] BranchIdx = '0;
  logic       CondIn = 1'b0;
  logic       LutWrEn = 1'b0;
  logic [4:0] LutWrIdx = '0;
  logic [9:0] LutWrData = '0;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Done;
  logic       BranchTaken;

  int n_cmp = 0;
  int n_mis = 0;

  pc_branch_unit #(.PCW(10), .LW(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Halt(Halt), .BranchEn(BranchEn), .BranchIdx(BranchIdx), .CondIn(CondIn),
    .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx), .LutWrData(LutWrData),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .BranchTaken(BranchTaken)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
    $display("t=%0t pc=%0d run=%0b done=%0b bt=%0b", $time, ProgCtr, Running, Done, BranchTaken);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ProgCtr !== 10'd0) begin n_mis++; $display("FAIL rst_pc got %0d want 0", ProgCtr); end
    n_cmp++; if (Running !== 1'b0) begin n_mis++; $display("FAIL rst_running got %0b want 0", Running); end
    n_cmp++; if (Done !== 1'b0) begin n_mis++; $display("FAIL rst_done got %0b want 0", Done); end
    n_cmp++; if (BranchTaken !== 1'b0) begin n_mis++; $display("FAIL rst_bt got %0b want 0", BranchTaken); end
    tick();
    n_cmp++; if (Running !== 1'b0) begin n_mis++; $display("FAIL idle_hold_running got %0b want 0", Running); end
  endtask

  task automatic test_sequential();
    Start = 1'b1; StartAddr = 10'd10;
    tick();
    Start = 1'b0;
    n_cmp++; if (Running !== 1'b1) begin n_mis++; $display("FAIL t1_running got %0b want 1", Running); end
    n_cmp++; if (ProgCtr !== 10'd10) begin n_mis++; $display("FAIL t1_pc_start got %0d want 10", ProgCtr); end
    for (int k = 11; k <= 13; k++) begin
      tick();
      n_cmp++; if (ProgCtr !== 10'(k)) begin n_mis++; $display("FAIL t1_pc_seq got %0d want %0d", ProgCtr, k); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    LutWrEn = 1'b1; LutWrIdx = 5'd3; LutWrData = 10'd200;
    tick();
    // Write committed in the same cycle as Start
    LutWrIdx = 5'd4; LutWrData = 10'd77; Start = 1'b1; StartAddr = 10'd20;
    tick();
    LutWrEn = 1'b0; Start = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd20) begin n_mis++; $display("FAIL t2_pc_start got %0d want 20", ProgCtr); end
    BranchEn = 1'b1; BranchIdx = 5'd3; CondIn = 1'b1;
    tick();
    n_cmp++; if (ProgCtr !== 10'd200) begin n_mis++; $display("FAIL t2_taken_pc got %0d want 200", ProgCtr); end
    n_cmp++; if (BranchTaken !== 1'b1) begin n_mis++; $display("FAIL t2_taken_bt got %0b want 1", BranchTaken); end
    CondIn = 1'b0;
    tick();
    n_cmp++; if (ProgCtr !== 10'd201) begin n_mis++; $display("FAIL t2_nottaken_pc got %0d want 201", ProgCtr); end
    n_cmp++; if (BranchTaken !== 1'b0) begin n_mis++; $display("FAIL t2_nottaken_bt got %0b want 0", BranchTaken); end
    BranchIdx = 5'd4; CondIn = 1'b1;
    tick();
    n_cmp++; if (ProgCtr !== 10'd77) begin n_mis++; $display("FAIL t2_startwr_pc got %0d want 77", ProgCtr); end
  endtask

  task automatic test_back_to_back();
    BranchIdx = 5'd3; CondIn = 1'b1;
    tick();
    n_cmp++; if (ProgCtr !== 10'd200 || BranchTaken !== 1'b1) begin n_mis++; $display("FAIL b2b_pc got %0d/%0b want 200/1", ProgCtr, BranchTaken); end
    BranchEn = 1'b0; CondIn = 1'b0;
    tick();
    n_cmp++; if (ProgCtr !== 10'd201 || BranchTaken !== 1'b0) begin n_mis++; $display("FAIL b2b_after got %0d/%0b want 201/0", ProgCtr, BranchTaken); end
  endtask

  task automatic test_wrap();
    do_reset();
    Start = 1'b1; StartAddr = 10'd1023;
    tick();
    Start = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd1023) begin n_mis++; $display("FAIL t3_pc_top got %0d want 1023", ProgCtr); end
    tick();
    n_cmp++; if (ProgCtr !== 10'd0) begin n_mis++; $display("FAIL t3_wrap got %0d want 0", ProgCtr); end
    tick();
    n_cmp++; if (ProgCtr !== 10'd1) begin n_mis++; $display("FAIL t3_after_wrap got %0d want 1", ProgCtr); end
  endtask

  task automatic test_halt();
    Halt = 1'b1; BranchEn = 1'b1; CondIn = 1'b1; BranchIdx = 5'd0;
    tick();
    Halt = 1'b0; BranchEn = 1'b0; CondIn = 1'b0;
    n_cmp++; if (Done !== 1'b1) begin n_mis++; $display("FAIL t4_done got %0b want 1", Done); end
    n_cmp++; if (Running !== 1'b0) begin n_mis++; $display("FAIL t4_running got %0b want 0", Running); end
    n_cmp++; if (ProgCtr !== 10'd1) begin n_mis++; $display("FAIL t4_pc_hold got %0d want 1", ProgCtr); end
    n_cmp++; if (BranchTaken !== 1'b0) begin n_mis++; $display("FAIL t4_bt got %0b want 0", BranchTaken); end
    // Writes allowed while DONE
    LutWrEn = 1'b1; LutWrIdx = 5'd9; LutWrData = 10'd333;
    tick();
    LutWrIdx = 5'd3; LutWrData = 10'd444;
    tick();
    LutWrEn = 1'b0;
    n_cmp++; if (Done !== 1'b1 || ProgCtr !== 10'd1) begin n_mis++; $display("FAIL t4_done_hold got %0b/%0d want 1/1", Done, ProgCtr); end
    Start = 1'b1; StartAddr = 10'd5;
    tick();
    Start = 1'b0;
    n_cmp++; if (Running !== 1'b1 || Done !== 1'b0) begin n_mis++; $display("FAIL t4_restart got run=%0b done=%0b want 1/0", Running, Done); end
    n_cmp++; if (ProgCtr !== 10'd5) begin n_mis++; $display("FAIL t4_restart_pc got %0d want 5", ProgCtr); end
    BranchEn = 1'b1; BranchIdx = 5'd9; CondIn = 1'b1;
    tick();
    BranchEn = 1'b0; CondIn = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd333) begin n_mis++; $display("FAIL t4_done_wr got %0d want 333", ProgCtr); end
  endtask

  task automatic test_run_write_and_reset();
    LutWrEn = 1'b1; LutWrIdx = 5'd7; LutWrData = 10'd99;
    tick();
    LutWrEn = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd334) begin n_mis++; $display("FAIL t5_pc_inc got %0d want 334", ProgCtr); end
    BranchEn = 1'b1; BranchIdx = 5'd7; CondIn = 1'b1;
    tick();
    BranchEn = 1'b0; CondIn = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd0) begin n_mis++; $display("FAIL t5_dropped_wr got %0d want 0", ProgCtr); end
    tick();
    // Reset beats a concurrent Start
    Reset = 1'b1; Start = 1'b1; StartAddr = 10'd50;
    tick();
    Reset = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin n_mis++; $display("FAIL t5_midrun_reset got %0d/%0b want 0/0", ProgCtr, Running); end
    tick();
    Start = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd50) begin n_mis++; $display("FAIL t5_start_after_reset got %0d want 50", ProgCtr); end
    BranchEn = 1'b1; BranchIdx = 5'd3; CondIn = 1'b1;
    tick();
    BranchEn = 1'b0; CondIn = 1'b0;
    n_cmp++; if (ProgCtr !== 10'd0) begin n_mis++; $display("FAIL t5_lut_cleared got %0d want 0", ProgCtr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_run_write_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
